// File: rtl/ll_ht_cmd_dispatch.sv
// ll_ht_cmd_dispatch
// Routes a hash-table command stream to one of DIR_CNT engine ports by opcode.
// Only one engine may hold outstanding commands at a time, so results can only
// come back from a single engine and the result mux never sees two valids.
// Outstanding commands retire on res_fire_i, the result handshake after the mux.
//
// The command word is carried flat; the opcode occupies cmd[OPC_W-1:0].
//
//   state  | meaning
//   IDLE   | nothing outstanding; any valid opcode may be accepted
//   ACTIVE | commands outstanding to engine last_sel; only that engine accepted
module ll_ht_cmd_dispatch #(
  parameter int DIR_CNT      = 3,
  parameter int MAX_INFLIGHT = 4,
  parameter int DROP_CNT_W   = 16,
  parameter int CMD_W        = 32,
  parameter int OPC_W        = 2,
  localparam int INF_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [CMD_W-1:0]                cmd_in_cmd,
  input  logic                            cmd_in_valid,
  output logic                            cmd_in_ready,
  output logic [DIR_CNT-1:0][CMD_W-1:0]   cmd_out_cmd,
  output logic [DIR_CNT-1:0]              cmd_out_valid,
  input  logic [DIR_CNT-1:0]              cmd_out_ready,
  input  logic                            res_fire_i,
  output logic [INF_W-1:0]                inflight_o,
  output logic                            busy_o,
  output logic [DROP_CNT_W-1:0]           drop_cnt_o,
  output logic                            underflow_o
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [INF_W-1:0] MAX_INF = INF_W'(MAX_INFLIGHT);

  state_t             state;
  state_t             state_nxt;
  logic [OPC_W-1:0]   last_sel;
  logic [OPC_W-1:0]   sel;
  logic               sel_ok;
  logic               port_free;
  logic               gate;
  logic               accept;
  logic               drop;
  logic               underflow_evt;
  logic [INF_W-1:0]   inflight_nxt;

  // Dispatch gating, accept/drop decode, in-flight arithmetic and next state.
  always_comb begin
    sel       = cmd_in_cmd[OPC_W-1:0];
    sel_ok    = (32'(sel) < 32'(DIR_CNT));
    port_free = 1'b0;
    for (int i = 0; i < DIR_CNT; i++) begin
      if (sel == OPC_W'(i)) begin
        port_free = !cmd_out_valid[i] || cmd_out_ready[i];
      end
    end
    // Head-of-line blocking: a different engine waits until inflight drains.
    gate         = (state == IDLE) || ((sel == last_sel) && (inflight_o < MAX_INF));
    // Invalid opcodes are always consumed so they can never wedge the stream.
    cmd_in_ready = sel_ok ? (gate && port_free) : 1'b1;
    accept       = cmd_in_valid && sel_ok && gate && port_free;
    drop         = cmd_in_valid && !sel_ok;

    underflow_evt = 1'b0;
    inflight_nxt  = inflight_o;
    case ({accept, res_fire_i})
      2'b10: inflight_nxt = inflight_o + INF_W'(1);
      2'b01: begin
        if (inflight_o == '0) begin
          underflow_evt = 1'b1;
        end else begin
          inflight_nxt = inflight_o - INF_W'(1);
        end
      end
      default: inflight_nxt = inflight_o;
    endcase

    state_nxt = (inflight_nxt == '0) ? IDLE : ACTIVE;
  end

  // State, counters and the per-port output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      inflight_o    <= '0;
      last_sel      <= '0;
      drop_cnt_o    <= '0;
      underflow_o   <= 1'b0;
      cmd_out_valid <= '0;
      cmd_out_cmd   <= '0;
    end else begin
      state      <= state_nxt;
      inflight_o <= inflight_nxt;
      if (accept) begin
        last_sel <= sel;
      end
      if (underflow_evt) begin
        underflow_o <= 1'b1;
      end
      if (drop && (drop_cnt_o != '1)) begin
        drop_cnt_o <= drop_cnt_o + DROP_CNT_W'(1);
      end
      for (int i = 0; i < DIR_CNT; i++) begin
        if (accept && (sel == OPC_W'(i))) begin
          cmd_out_valid[i] <= 1'b1;
          cmd_out_cmd[i]   <= cmd_in_cmd;
        end else if (cmd_out_ready[i]) begin
          cmd_out_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign busy_o = (inflight_o != '0) || (|cmd_out_valid);

endmodule

// File: tb/tb_ll_ht_cmd_dispatch.sv
// Scoreboard bench for ll_ht_cmd_dispatch: expected commands are queued per
// engine port when driven and popped when that port completes a handshake.
module tb_ll_ht_cmd_dispatch;

  localparam int DIR_CNT = 3;
  localparam int CMD_W   = 32;

  logic                          clk_i = 1'b0;
  logic                          rst_i;
  logic [CMD_W-1:0]              cmd_in_cmd;
  logic                          cmd_in_valid;
  logic                          cmd_in_ready;
  logic [DIR_CNT-1:0][CMD_W-1:0] cmd_out_cmd;
  logic [DIR_CNT-1:0]            cmd_out_valid;
  logic [DIR_CNT-1:0]            cmd_out_ready;
  logic                          res_fire_i;
  logic [2:0]                    inflight_o;
  logic                          busy_o;
  logic [15:0]                   drop_cnt_o;
  logic                          underflow_o;

  int n_chk  = 0;
  int n_fail = 0;
  int seq    = 0;
  logic [31:0] exp_q [DIR_CNT][$];
  logic [31:0] held;

  ll_ht_cmd_dispatch #(
    .DIR_CNT(3), .MAX_INFLIGHT(4), .DROP_CNT_W(16), .CMD_W(32), .OPC_W(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_in_cmd(cmd_in_cmd), .cmd_in_valid(cmd_in_valid), .cmd_in_ready(cmd_in_ready),
    .cmd_out_cmd(cmd_out_cmd), .cmd_out_valid(cmd_out_valid), .cmd_out_ready(cmd_out_ready),
    .res_fire_i(res_fire_i), .inflight_o(inflight_o), .busy_o(busy_o),
    .drop_cnt_o(drop_cnt_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tb_chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a new command with a unique sequence tag above the opcode.
  task automatic drive(input logic [1:0] op);
    seq++;
    cmd_in_cmd   = {seq[29:0], op};
    cmd_in_valid = 1'b1;
  endtask

  task automatic push(input int port);
    exp_q[port].push_back(cmd_in_cmd);
  endtask

  // Output monitor: samples just before each rising edge, away from the edge.
  always @(negedge clk_i) begin
    #3;
    if (!rst_i) begin
      for (int i = 0; i < DIR_CNT; i++) begin
        if (cmd_out_valid[i] && cmd_out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            tb_chk($sformatf("unexpected_out%0d", i), cmd_out_cmd[i], 32'hffff_ffff);
          end else begin
            tb_chk($sformatf("out%0d_cmd", i), cmd_out_cmd[i], exp_q[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; cmd_in_cmd = '0; cmd_in_valid = 1'b0;
    cmd_out_ready = 3'b111; res_fire_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    tb_chk("rst_inflight", 32'(inflight_o), 0);
    tb_chk("rst_busy", 32'(busy_o), 0);
    tb_chk("rst_drop", 32'(drop_cnt_o), 0);
    tb_chk("rst_uf", 32'(underflow_o), 0);
    tb_chk("rst_valid", 32'(cmd_out_valid), 0);
    tb_chk("rst_cmd0", cmd_out_cmd[0], 0);

    // Burst of SEARCH to engine 0: four go back-to-back, then the gate closes.
    @(negedge clk_i);
    for (int k = 0; k < 4; k++) begin
      drive(2'd0); #1;
      tb_chk("burst_rdy", 32'(cmd_in_ready), 1);
      push(0);
      @(negedge clk_i);
    end
    drive(2'd0); #1;
    tb_chk("burst_full_rdy", 32'(cmd_in_ready), 0);
    tb_chk("burst_inflight", 32'(inflight_o), 4);
    tb_chk("burst_v0", 32'(cmd_out_valid), 3'b001);
    @(negedge clk_i); #1;
    tb_chk("burst_drained_v", 32'(cmd_out_valid), 0);
    tb_chk("burst_still_blk", 32'(cmd_in_ready), 0);
    @(negedge clk_i);
    res_fire_i = 1'b1; #1;
    tb_chk("burst_fire_rdy", 32'(cmd_in_ready), 0);
    @(negedge clk_i);
    res_fire_i = 1'b0; #1;
    tb_chk("burst_after_fire_inf", 32'(inflight_o), 3);
    tb_chk("burst_after_fire_rdy", 32'(cmd_in_ready), 1);
    push(0);
    @(negedge clk_i);
    drive(2'd0); #1;
    tb_chk("burst_refull_rdy", 32'(cmd_in_ready), 0);
    tb_chk("burst_refull_inf", 32'(inflight_o), 4);
    cmd_in_valid = 1'b0;
    res_fire_i = 1'b1;
    repeat (4) @(negedge clk_i);
    res_fire_i = 1'b0; #1;
    tb_chk("burst_drain_inf", 32'(inflight_o), 0);
    tb_chk("burst_drain_busy", 32'(busy_o), 0);

    // Engine switch: DELETE waits behind an outstanding INSERT.
    @(negedge clk_i);
    drive(2'd1); #1;
    tb_chk("sw_ins_rdy", 32'(cmd_in_ready), 1);
    push(1);
    @(negedge clk_i);
    drive(2'd2); #1;
    tb_chk("sw_del_stall", 32'(cmd_in_ready), 0);
    tb_chk("sw_inf1", 32'(inflight_o), 1);
    repeat (2) begin
      @(negedge clk_i); #1;
      tb_chk("sw_del_stall_hold", 32'(cmd_in_ready), 0);
    end
    @(negedge clk_i);
    res_fire_i = 1'b1; #1;
    tb_chk("sw_fire_cycle_rdy", 32'(cmd_in_ready), 0);
    @(negedge clk_i);
    res_fire_i = 1'b0; #1;
    tb_chk("sw_inf0", 32'(inflight_o), 0);
    tb_chk("sw_del_rdy", 32'(cmd_in_ready), 1);
    push(2);
    @(negedge clk_i);
    cmd_in_valid = 1'b0; #1;
    tb_chk("sw_only_port2", 32'(cmd_out_valid), 3'b100);
    tb_chk("sw_inf_del", 32'(inflight_o), 1);
    res_fire_i = 1'b1;
    @(negedge clk_i);
    res_fire_i = 1'b0; #1;
    tb_chk("sw_end_inf", 32'(inflight_o), 0);

    // Backpressure on engine 1.
    @(negedge clk_i);
    cmd_out_ready[1] = 1'b0;
    drive(2'd1); #1;
    tb_chk("bp_first_rdy", 32'(cmd_in_ready), 1);
    push(1);
    held = cmd_in_cmd;
    @(negedge clk_i);
    drive(2'd1); #1;
    tb_chk("bp_second_blk", 32'(cmd_in_ready), 0);
    repeat (2) begin
      @(negedge clk_i); #1;
      tb_chk("bp_hold_valid", 32'(cmd_out_valid), 3'b010);
      tb_chk("bp_hold_cmd", cmd_out_cmd[1], held);
      tb_chk("bp_hold_blk", 32'(cmd_in_ready), 0);
    end
    @(negedge clk_i);
    cmd_out_ready[1] = 1'b1; #1;
    tb_chk("bp_rise_rdy", 32'(cmd_in_ready), 1);
    push(1);
    held = cmd_in_cmd;
    @(negedge clk_i);
    cmd_in_valid = 1'b0; #1;
    tb_chk("bp_second_cmd", cmd_out_cmd[1], held);
    tb_chk("bp_second_valid", 32'(cmd_out_valid), 3'b010);
    tb_chk("bp_inf2", 32'(inflight_o), 2);

    // Accept and res_fire in the same cycle at inflight 2.
    @(negedge clk_i);
    drive(2'd1);
    res_fire_i = 1'b1; #1;
    tb_chk("sim_rdy", 32'(cmd_in_ready), 1);
    push(1);
    @(negedge clk_i);
    cmd_in_valid = 1'b0;
    res_fire_i = 1'b0; #1;
    tb_chk("sim_inf2", 32'(inflight_o), 2);
    res_fire_i = 1'b1;
    repeat (2) @(negedge clk_i);
    res_fire_i = 1'b0; #1;
    tb_chk("sim_drain_inf", 32'(inflight_o), 0);

    // Invalid opcode and underflow.
    @(negedge clk_i);
    drive(2'd3); #1;
    tb_chk("inv_rdy", 32'(cmd_in_ready), 1);
    @(negedge clk_i);
    cmd_in_valid = 1'b0; #1;
    tb_chk("inv_no_valid", 32'(cmd_out_valid), 0);
    tb_chk("inv_drop1", 32'(drop_cnt_o), 1);
    tb_chk("inv_inf0", 32'(inflight_o), 0);
    tb_chk("uf_before", 32'(underflow_o), 0);
    res_fire_i = 1'b1;
    @(negedge clk_i);
    res_fire_i = 1'b0; #1;
    tb_chk("uf_set", 32'(underflow_o), 1);
    tb_chk("uf_inf0", 32'(inflight_o), 0);
    repeat (3) @(negedge clk_i);
    #1;
    tb_chk("uf_sticky", 32'(underflow_o), 1);
    @(negedge clk_i);
    drive(2'd3);
    repeat (69999) @(negedge clk_i);
    cmd_in_valid = 1'b0; #1;
    tb_chk("drop_sat", 32'(drop_cnt_o), 65535);
    tb_chk("drop_no_valid", 32'(cmd_out_valid), 0);

    // Mid-operation reset with inflight 3 and port 0 holding a command.
    @(negedge clk_i);
    for (int k = 0; k < 3; k++) begin
      drive(2'd0);
      push(0);
      @(negedge clk_i);
    end
    cmd_in_valid = 1'b0;
    cmd_out_ready[0] = 1'b0;
    rst_i = 1'b1; #1;
    tb_chk("pre_rst_inf3", 32'(inflight_o), 3);
    tb_chk("pre_rst_v0", 32'(cmd_out_valid), 3'b001);
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_q[0].delete();
    drive(2'd2); #1;
    tb_chk("mrst_inflight", 32'(inflight_o), 0);
    tb_chk("mrst_valid", 32'(cmd_out_valid), 0);
    tb_chk("mrst_cmd0", cmd_out_cmd[0], 0);
    tb_chk("mrst_busy", 32'(busy_o), 0);
    tb_chk("mrst_drop", 32'(drop_cnt_o), 0);
    tb_chk("mrst_uf", 32'(underflow_o), 0);
    tb_chk("mrst_del_rdy", 32'(cmd_in_ready), 1);
    push(2);
    @(negedge clk_i);
    cmd_in_valid = 1'b0; #1;
    tb_chk("mrst_del_valid", 32'(cmd_out_valid), 3'b100);
    cmd_out_ready[0] = 1'b1;
    res_fire_i = 1'b1;
    @(negedge clk_i);
    res_fire_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    tb_chk("end_busy", 32'(busy_o), 0);
    for (int i = 0; i < DIR_CNT; i++) begin
      tb_chk($sformatf("q%0d_empty", i), exp_q[i].size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ll_ht_cmd_dispatch.md
# ll_ht_cmd_dispatch

Command-side counterpart of the hash-table result mux. It accepts one hash-table command stream and routes each command by opcode to one of DIR_CNT engine ports (search/insert/delete) through a registered output stage. It limits in-flight commands so that results only ever return from a single engine at a time, which keeps the one-valid-at-a-time condition on the result mux true. Outstanding commands are retired by observing the result handshake downstream of the mux.

## Interface
- DIR_CNT, 3, number of engine ports; opcode value k routes to port k.
- MAX_INFLIGHT, 4, max commands outstanding, all to the same engine (≥1).
- DROP_CNT_W, 16, width of the dropped-command counter.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset; synchronous, active-high.
- cmd_in  ll_ht_cmd_if.slave  —  command input: cmd (ll_ht_command_t with field opcode), valid, ready.
- cmd_out [DIR_CNT-1:0]  ll_ht_cmd_if.master  —  per-engine command outputs.
- res_fire_i  in  1  pulses high for one cycle per completed result handshake (valid & ready at the mux output).
- inflight_o  out  $clog2(MAX_INFLIGHT+1)  current outstanding count.
- busy_o  out  1  inflight_o != 0 or any cmd_out valid.
- drop_cnt_o  out  DROP_CNT_W  saturating count of dropped commands.
- underflow_o  out  1  sticky; set when res_fire_i arrives with inflight 0.

## Operation
- sel = cmd_in.cmd.opcode. Opcode ≥ DIR_CNT is invalid.
- State IDLE (inflight==0): any valid opcode may be accepted. On accept, go to ACTIVE(sel) and set last_sel=sel.
- State ACTIVE(k) (inflight>0):
  - A command may be accepted only if sel==k and inflight<MAX_INFLIGHT.
  - sel≠k stalls until inflight returns to 0. This is head-of-line blocking by design.
- Output stage: one register per port (cmd, valid). Since only one port is active at a time, at most one port's register is valid at any instant.
  - Accept condition: cmd_in.valid & gate & (!out_valid[sel] | cmd_out[sel].ready).
  - cmd_in.ready = gate & (!out_valid[sel] | cmd_out[sel].ready), computed combinationally from sel.
  - On accept, out_valid[sel] is set and the cmd is registered.
  - out_valid[i] clears when cmd_out[i].ready is high and there is no new accept to port i.
- Invalid opcode:
  - cmd_in.ready=1 unconditionally.
  - The command is consumed, not dispatched, and does not affect inflight.
  - drop_cnt increments and saturates at all-ones.
- inflight arithmetic:
  - +1 on valid accept, −1 on res_fire_i.
  - Both in the same cycle: unchanged.
  - res_fire_i at 0: stays 0 and sets underflow_o.
  - Return to IDLE when inflight reaches 0.
- Bounds: inflight never exceeds MAX_INFLIGHT; the gate guarantees this.

## Timing
- Reset values: all cmd_out valid=0, cmd_out cmd=0, inflight_o=0, last_sel=0, busy_o=0, drop_cnt_o=0, underflow_o=0. Reset asserted mid-operation discards any registered commands and the in-flight count in the same edge.
- Latency: an accept at edge N gives cmd_out[sel].valid high after edge N, with the cmd unchanged.
- Throughput: one command per cycle to the same engine while the engine holds ready=1 and inflight<MAX_INFLIGHT.
- Output valid/cmd stay stable while ready=0. cmd_in.ready may depend on cmd_in.cmd, but not on cmd_in.valid.
- Engine switch: the first command to a new engine is accepted in the cycle after the res_fire_i that brings inflight to 0, at the earliest. It is accepted in the same cycle only if inflight was already 0.
- drop_cnt_o and underflow_o update one cycle after the triggering event.

## Test plan
- Setup: DIR_CNT=3, MAX_INFLIGHT=4.
- Burst to same engine: 6 SEARCH (opcode 0), engine ready=1, no res_fire. Required: 4 accepted back-to-back, cmd_out[0] valid for 4 cycles, then cmd_in.ready=0 and inflight_o=4. One res_fire gives one more accept.
- Engine switch: INSERT accepted (inflight 1), then DELETE presented. Required: DELETE stalled until res_fire_i; inflight goes 1→0, then DELETE accepted the next cycle, and only cmd_out[2] becomes valid.
- Backpressure: cmd_out[1].ready=0 with 2 INSERTs. Required: the first INSERT is held stable in cmd_out[1], the second is not accepted, and it is accepted in the cycle ready rises.
- Simultaneous accept and res_fire_i at inflight=2. Required: inflight stays 2.
- Invalid opcode 3 and res_fire_i with inflight 0. Required: command consumed, no cmd_out valid, drop_cnt_o=1, underflow_o=1 and sticky. drop_cnt_o saturates at 65535 after 70000 drops.
- Reset: assert rst_i for 1 cycle with inflight=3 and cmd_out[0] valid. Required: all outputs at reset values on the next cycle, and a new DELETE is accepted immediately.
